// File: rtl/reg_bus_pkg.sv
// Shared types and defaults for the register-bus initiator.
// Optional feature macro: REG_BUS_VERIFY_EN (write read-back verify).
package reg_bus_pkg;

  localparam int unsigned REG_BUS_DW   = 16;
  localparam int unsigned REG_BUS_NREG = 4;

  // Encoding is fixed; VERIFY keeps its code even when the feature is built out.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_VERIFY = 2'd2,
    ST_RESP   = 2'd3
  } reg_bus_state_e;

  // Address width for a given target count, never below one bit.
  function automatic int unsigned reg_bus_aw(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/reg_bus_decode.sv
// Target index decoder: one-hot select plus range flag.
module reg_bus_decode
  import reg_bus_pkg::*;
#(
  parameter  int unsigned NREG = REG_BUS_NREG,
  localparam int unsigned AW   = reg_bus_aw(NREG)
) (
  input  logic [AW-1:0]   idx,
  input  logic            en,
  output logic [NREG-1:0] onehot,
  output logic            in_range
);

  // Range check is independent of en; the select only fires when enabled and in range.
  always_comb begin
    onehot   = '0;
    in_range = (32'(idx) < NREG);
    for (int unsigned i = 0; i < NREG; i++) begin
      onehot[i] = en && (32'(idx) == i);
    end
  end

endmodule

// File: rtl/reg_bus_initiator.sv
// Single-outstanding command initiator for the simple register bus.
// Optional feature macro: REG_BUS_VERIFY_EN adds a read-back VERIFY cycle after writes.
module reg_bus_initiator
  import reg_bus_pkg::*;
#(
  parameter  int unsigned DW   = REG_BUS_DW,
  parameter  int unsigned NREG = REG_BUS_NREG,
  localparam int unsigned AW   = reg_bus_aw(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_wr,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic [NREG-1:0] bus_sel,
  output logic            bus_wr,
  output logic [DW-1:0]   bus_wdata,
  input  logic [DW-1:0]   bus_rdata
);

  localparam logic [1:0] IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] ACCESS = 2'(ST_ACCESS);
  localparam logic [1:0] VERIFY = 2'(ST_VERIFY);
  localparam logic [1:0] RESP   = 2'(ST_RESP);

  logic [1:0]      state_q,     state_d;
  logic            wr_q,        wr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q,   rsp_err_d;
  logic [NREG-1:0] bus_sel_q,   bus_sel_d;
  logic            bus_wr_q,    bus_wr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
`ifdef REG_BUS_VERIFY_EN
  logic [DW-1:0]   wdata_q,     wdata_d;
`endif

  logic            dec_en;
  logic [NREG-1:0] dec_onehot;
  logic            dec_in_range;

  assign dec_en = cmd_valid && (state_q == IDLE);

  reg_bus_decode #(
    .NREG (NREG)
  ) u_decode (
    .idx      (cmd_addr),
    .en       (dec_en),
    .onehot   (dec_onehot),
    .in_range (dec_in_range)
  );

  // Next-state and next-output logic; bus outputs default to idle every cycle.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bus_sel_d   = '0;
    bus_wr_d    = 1'b0;
    bus_wdata_d = '0;
`ifdef REG_BUS_VERIFY_EN
    wdata_d     = wdata_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          wr_d = cmd_wr;
`ifdef REG_BUS_VERIFY_EN
          wdata_d = cmd_wdata;
`endif
          if (!dec_in_range) begin
            // Out-of-range: respond at once, bus untouched.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ACCESS;
            bus_sel_d   = dec_onehot;
            bus_wr_d    = cmd_wr;
            bus_wdata_d = cmd_wr ? cmd_wdata : '0;
          end
        end
      end

      ACCESS: begin
        if (wr_q) begin
`ifdef REG_BUS_VERIFY_EN
          state_d   = VERIFY;
          bus_sel_d = bus_sel_q;
`else
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
`endif
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus_rdata;
          rsp_err_d   = 1'b0;
        end
      end

      VERIFY: begin
`ifdef REG_BUS_VERIFY_EN
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = bus_rdata;
        rsp_err_d   = (bus_rdata != wdata_q);
`else
        state_d = IDLE;
`endif
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction and drops the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      bus_sel_q   <= '0;
      bus_wr_q    <= 1'b0;
      bus_wdata_q <= '0;
`ifdef REG_BUS_VERIFY_EN
      wdata_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      bus_sel_q   <= bus_sel_d;
      bus_wr_q    <= bus_wr_d;
      bus_wdata_q <= bus_wdata_d;
`ifdef REG_BUS_VERIFY_EN
      wdata_q     <= wdata_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wr    = bus_wr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Randomized self-checking bench for reg_bus_initiator (NREG=3, DW=16).
// Honours REG_BUS_VERIFY_EN the same way as the design.
module tb_reg_bus_initiator;

  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 3;
  localparam int unsigned AW   = 2;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_wr;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [NREG-1:0] bus_sel;
  logic            bus_wr;
  logic [DW-1:0]   bus_wdata;
  logic [DW-1:0]   bus_rdata;

  int vectors = 0;
  int errors  = 0;

  // Bus targets (physical) and the transaction-level shadow of what they should hold.
  logic [DW-1:0] tgt    [NREG];
  logic [DW-1:0] shadow [NREG];
  bit            stuck  [NREG];

  reg_bus_initiator #(
    .DW   (DW),
    .NREG (NREG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus_sel   (bus_sel),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Targets latch wdata on sel & wr; a stuck target always holds zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NREG); i++) begin
      if (bus_sel[i] && bus_wr) tgt[i] <= stuck[i] ? '0 : bus_wdata;
    end
  end

  // Targets drive rdata only when selected for a read.
  always_comb begin
    bus_rdata = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (bus_sel[i] && !bus_wr) bus_rdata = bus_rdata | tgt[i];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One command, called at a negedge; returns at the negedge after the response handshake.
  task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int stall);
    bit            in_rng;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    logic [NREG-1:0] exp_sel;
    int            n;
    in_rng  = (32'(addr) < NREG);
    exp_sel = in_rng ? NREG'(1) << addr : '0;
    if (!in_rng) begin
      exp_rd = '0; exp_err = 1'b1;
    end else if (wr) begin
      shadow[addr] = stuck[addr] ? '0 : data;
`ifdef REG_BUS_VERIFY_EN
      exp_rd  = shadow[addr];
      exp_err = (shadow[addr] != data);
`else
      exp_rd  = '0;
      exp_err = 1'b0;
`endif
    end else begin
      exp_rd = shadow[addr]; exp_err = 1'b0;
    end

    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data;
    rsp_ready = (stall == 0);
    n = 0;
    while (!cmd_ready && n < 16) begin
      @(negedge clk); n++;
    end
    check_eq("cmd_ready_before", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    // Scramble the command port: nothing downstream may follow it now.
    cmd_valid = 1'b0; cmd_wr = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    check_eq("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    if (in_rng) begin
      check_eq("access_sel", 32'(bus_sel), 32'(exp_sel));
      check_eq("access_wr", 32'(bus_wr), 32'(wr));
      check_eq("access_wdata", 32'(bus_wdata), wr ? 32'(data) : 32'd0);
      check_eq("access_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
`ifdef REG_BUS_VERIFY_EN
      if (wr) begin
        check_eq("verify_sel", 32'(bus_sel), 32'(exp_sel));
        check_eq("verify_wr", 32'(bus_wr), 32'd0);
        check_eq("verify_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
      end
`endif
      if (wr) check_eq("target_data", 32'(tgt[addr]), 32'(shadow[addr]));
    end
    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_eq("resp_bus_idle", {bus_wr, 15'd0, bus_wdata} | 32'(bus_sel), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(rsp_valid), 32'd1);
      check_eq("stall_rdata", 32'(rsp_rdata), 32'(exp_rd));
      check_eq("stall_err", 32'(rsp_err), 32'(exp_err));
      check_eq("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("cmd_ready_after", 32'(cmd_ready), 32'd1);
    check_eq("rsp_dropped", 32'(rsp_valid), 32'd0);
  endtask

  // Assert reset during the ACCESS cycle of a command.
  task automatic reset_in_access(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; rsp_ready = 1'b0;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("rst_access_sel", 32'(bus_sel), 32'(NREG'(1) << addr));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (wr) shadow[addr] = data;
    check_eq("rst_bus_dropped", 32'(bus_sel), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_target", 32'(tgt[addr]), 32'(shadow[addr]));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);
    end
    rsp_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < int'(NREG); i++) stuck[i] = 1'b0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("reset_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("reset_bus_sel", 32'(bus_sel), 32'd0);
    check_eq("reset_bus_wr", 32'(bus_wr), 32'd0);
    check_eq("reset_bus_wdata", 32'(bus_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_cmd_ready", 32'(cmd_ready), 32'd1);

    // Give every target a known value.
    for (int i = 0; i < int'(NREG); i++) run_cmd(1'b1, AW'(i), DW'($urandom), 0);

    // Directed: write/read A5C3 on target 2, out-of-range, long stall.
    run_cmd(1'b1, 2'd2, 16'hA5C3, 0);
    run_cmd(1'b0, 2'd2, 16'h0000, 0);
    run_cmd(1'b0, 2'd3, 16'h1234, 0);
    run_cmd(1'b1, 2'd3, 16'hBEEF, 2);
    run_cmd(1'b0, 2'd1, 16'h0000, 5);

    // Reset mid-read, then a write whose ACCESS edge coincides with reset.
    reset_in_access(1'b0, 2'd2, 16'h0000);
    reset_in_access(1'b1, 2'd0, 16'h5A5A);
    run_cmd(1'b0, 2'd0, 16'h0000, 0);

`ifdef REG_BUS_VERIFY_EN
    stuck[1] = 1'b1;
    run_cmd(1'b1, 2'd1, 16'h0001, 0);
    run_cmd(1'b0, 2'd1, 16'h0000, 0);
    stuck[1] = 1'b0;
`endif

    // Randomized traffic with occasional stalls and idle gaps.
    for (int t = 0; t < 60; t++) begin
      int stall;
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_cmd(1'($urandom), AW'($urandom_range(0, 3)), DW'($urandom), stall);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/reg_bus_initiator.md
# reg_bus_initiator

Single-transaction initiator for the team's simple register bus (`sel`/`wr`/`wdata`/`rdata` targets that latch `wdata` on `sel & wr` and drive `rdata` only on `sel & ~wr`, else 0). It accepts read/write commands on a valid/ready port and decodes an address to a one-hot select across `NREG` targets. It runs exactly one bus access per command and returns read data and an error flag on a valid/ready response port. It sits between a control-path master (CPU shim, test sequencer) and a bank of register targets.

## Interface
- `DW`, 16, data width of bus and command/response data.
- `NREG`, 4, number of targets; `AW = $clog2(NREG)`, min 1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  AW  target index.
- `cmd_wdata`  in  DW  write data.
- `rsp_valid`  out  1  response held until `rsp_ready`.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  DW  read data (readback for verified writes, else 0 on writes).
- `rsp_err`  out  1  address out of range or verify mismatch.
- `bus_sel`  out  NREG  one-hot target select.
- `bus_wr`  out  1  write strobe, shared.
- `bus_wdata`  out  DW  write data, shared.
- `bus_rdata`  in  DW  OR of all target `rdata` (zero from unselected targets).

## Operation
- FSM states: IDLE, ACCESS, VERIFY (only with macro), RESP.
- IDLE:
  - `cmd_ready=1`.
  - On handshake, latch `wr`/`addr`/`wdata`.
  - If `addr >= NREG`, go to RESP with `err=1`, `rdata=0` and no bus activity.
  - Otherwise go to ACCESS.
- ACCESS (one cycle):
  - `bus_sel` = one-hot of the latched addr; `bus_wr` = latched wr.
  - `bus_wdata` = latched data on writes, 0 on reads.
  - Read: capture `bus_rdata` into `rsp_rdata` at the closing edge, then RESP.
  - Write: the target latches at the closing edge. Go to VERIFY if enabled, else RESP with `rdata=0`, `err=0`.
- VERIFY (one cycle):
  - Same `bus_sel`, `bus_wr=0`.
  - Capture `bus_rdata` into `rsp_rdata`; `rsp_err = (bus_rdata != latched wdata)`. Then RESP.
- RESP:
  - `rsp_valid=1`; `rsp_rdata`/`rsp_err` stable.
  - On `rsp_ready`, go to IDLE.
- Outside ACCESS/VERIFY, `bus_sel=0`, `bus_wr=0` and `bus_wdata=0`. The bus is never driven in IDLE or RESP.
- `cmd_ready=0` in every non-IDLE state; exactly one transaction is outstanding at a time.

## Timing
- All outputs are flop-driven or decoded only from state and latched registers. No combinational path from `cmd_*` or `rsp_ready` to any output except `cmd_ready`, which is a state decode.
- Reset (takes effect at the edge where `rst=1`):
  - State IDLE.
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
  - `bus_sel=0`, `bus_wr=0`, `bus_wdata=0`.
  - `cmd_ready=1` from the first cycle after `rst` falls.
- Reset mid-transaction: abandon at once and drop the bus at that edge. A write whose ACCESS edge coincides with `rst=1` still reaches the target, because the target sees `sel & wr` at that edge.
- Latency from command handshake edge N:
  - ACCESS in cycle N+1.
  - `rsp_valid` in cycle N+2; N+3 with verify.
  - Out-of-range: `rsp_valid` in cycle N+1.
- Back-to-back: with `rsp_ready` held 1, a new command can be accepted in the cycle after the RESP handshake. Minimum period is 3 cycles, or 4 with verify.
- `rsp_ready` low stalls RESP indefinitely with outputs stable.

## Configuration
- `REG_BUS_VERIFY_EN`:
  - Defined: VERIFY state is present. Every write is read back, `rsp_rdata` returns the readback and `rsp_err` flags a mismatch.
  - Undefined: VERIFY and the compare logic are absent. Writes respond with `rdata=0`, `err=0`.

## Structure
- Package `reg_bus_pkg`:
  - state enum `reg_bus_state_e` (IDLE, ACCESS, VERIFY, RESP; encoding fixed, VERIFY always reserved).
  - default `DW`/`NREG` localparams.
- Sub-module `reg_bus_decode`: parameterised `NREG`; `AW`-bit index plus enable in, `NREG`-bit one-hot plus `in_range` out.

## Test plan
- Write `addr=2`, `data=16'hA5C3`, `rsp_ready=1`:
  - `bus_sel=4'b0100`, `bus_wr=1` for exactly one cycle.
  - Target 2 holds `A5C3`.
  - `rsp_err=0`; `rsp_valid` 2 cycles after the handshake, or 3 with verify, where `rsp_rdata=A5C3`.
- Read `addr=2` after that write: `bus_sel=4'b0100`, `bus_wr=0` for one cycle; `rsp_rdata=16'hA5C3`, `err=0`.
- Out-of-range, `NREG=3`, `addr=3`: no `bus_sel` activity; `rsp_valid` 1 cycle later with `err=1`, `rdata=0`.
- `rsp_ready` held low for 5 cycles:
  - `rsp_valid`/`rsp_rdata` stable.
  - `cmd_ready=0` throughout.
  - Next command accepted the cycle after the handshake.
- Reset asserted during ACCESS of a read: next cycle `bus_sel=0`, `rsp_valid=0`; `cmd_ready=1` after release; no response is ever produced.
- VERIFY only, target modelled stuck at `16'h0000`, write `16'h0001`: `rsp_err=1`, `rsp_rdata=16'h0000`.
